// File: rtl/adc_train_pattern_gen_if.sv
// Payload source and beat output bundle for adc_train_pattern_gen.
// master = the generator, slave = whoever feeds payload and consumes beats.
interface adc_train_pattern_gen_if #(
    parameter int unsigned ADC_PORTS = 2
);
    logic                    src_valid;
    logic                    src_ready;
    logic [ADC_PORTS*16-1:0] src_i_data;
    logic [ADC_PORTS*16-1:0] src_q_data;
    logic                    out_dvalid;
    logic [ADC_PORTS*16-1:0] out_i_data;
    logic [ADC_PORTS*16-1:0] out_q_data;

    modport master (
        input  src_valid, src_i_data, src_q_data,
        output src_ready, out_dvalid, out_i_data, out_q_data
    );

    modport slave (
        output src_valid, src_i_data, src_q_data,
        input  src_ready, out_dvalid, out_i_data, out_q_data
    );
endinterface

// File: rtl/adc_train_pattern_gen.sv
// ADC TX training pattern generator with programmable I-or-Q lane skew.
// Define TX_IDLE_PATTERN_EN to fill payload gaps in DATA with pattern beats.
module adc_train_pattern_gen #(
    parameter int unsigned ADC_PORTS   = 2,
    parameter int unsigned SKEW_MAX    = 15,
    parameter int unsigned GUARD_BEATS = 8,
    parameter int unsigned TIMEOUT     = 4096
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en_train,
    input  logic                          align_cmpl,
    input  logic                          skew_sel_qi,
    input  logic [3:0]                    skew_val,
    adc_train_pattern_gen_if.master       bus,
    output logic                          training,
    output logic                          train_timeout,
    output logic [1:0]                    state_o
);
    localparam int unsigned W  = ADC_PORTS * 16;
    localparam int unsigned TW = $clog2(TIMEOUT);
    localparam int unsigned GW = $clog2(GUARD_BEATS + 1);

`ifdef TX_IDLE_PATTERN_EN
    localparam bit IdlePattern = 1'b1;
`else
    localparam bit IdlePattern = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle = 2'd0, StTrain = 2'd1, StGuard = 2'd2, StData = 2'd3} state_e;

    state_e          state_q, state_d;
    logic            en_prev_q, align_prev_q;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic [GW-1:0]   grd_cnt_q, grd_cnt_d;
    logic            timeout_q, timeout_d;
    logic            skew_sel_q, skew_sel_d;
    logic [3:0]      skew_val_q, skew_val_d;
    logic            phase_q, phase_d;
    logic [W-1:0]    dline_q [SKEW_MAX];
    logic [W-1:0]    dline_d [SKEW_MAX];
    logic            dvalid_q, dvalid_d;
    logic [W-1:0]    out_i_q, out_i_d, out_q_q, out_q_d;
    logic            training_q, training_d;
    logic [1:0]      state_o_q, state_o_d;

    logic            en_rise, align_fall, timeout_hit;
    logic            pat, pay, beat;
    logic [W-1:0]    new_i, new_q, sk_in, sk_out;

    assign en_rise    = en_train & ~en_prev_q;
    assign align_fall = align_prev_q & ~align_cmpl;

    function automatic logic [W-1:0] pat_word(input logic ph, input logic q_lane);
        logic [W-1:0] w;
        w = '0;
        for (int k = 0; k < int'(ADC_PORTS); k++) begin
            // Pair B when sample parity differs from beat phase, else pair A.
            if (ph ^ k[0]) w[16*k +: 16] = q_lane ? 16'h0008 : 16'h0010;
            else           w[16*k +: 16] = q_lane ? 16'hFFF7 : 16'hFFEF;
        end
        return w;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            en_prev_q    <= 1'b0;
            align_prev_q <= 1'b0;
            to_cnt_q     <= '0;
            grd_cnt_q    <= '0;
            timeout_q    <= 1'b0;
            skew_sel_q   <= 1'b0;
            skew_val_q   <= '0;
            phase_q      <= 1'b0;
            for (int i = 0; i < int'(SKEW_MAX); i++) dline_q[i] <= '0;
            dvalid_q     <= 1'b0;
            out_i_q      <= '0;
            out_q_q      <= '0;
            training_q   <= 1'b0;
            state_o_q    <= 2'd0;
        end else begin
            state_q      <= state_d;
            en_prev_q    <= en_train;
            align_prev_q <= align_cmpl;
            to_cnt_q     <= to_cnt_d;
            grd_cnt_q    <= grd_cnt_d;
            timeout_q    <= timeout_d;
            skew_sel_q   <= skew_sel_d;
            skew_val_q   <= skew_val_d;
            phase_q      <= phase_d;
            for (int i = 0; i < int'(SKEW_MAX); i++) dline_q[i] <= dline_d[i];
            dvalid_q     <= dvalid_d;
            out_i_q      <= out_i_d;
            out_q_q      <= out_q_d;
            training_q   <= training_d;
            state_o_q    <= state_o_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        timeout_hit = 1'b0;
        unique case (state_q)
            StIdle:  if (en_rise) state_d = StTrain;
            StTrain: begin
                if (align_cmpl) begin
                    state_d = StGuard;
                end else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
                    state_d     = StIdle;
                    timeout_hit = 1'b1;
                end
            end
            StGuard: if (grd_cnt_q == GW'(GUARD_BEATS - 1)) state_d = StData;
            StData:  if (align_fall) state_d = StTrain;
        endcase
        if (!en_train) state_d = StIdle;
    end

    always_comb begin
        to_cnt_d   = (state_q == StTrain) ? to_cnt_q + 1'b1 : '0;
        grd_cnt_d  = (state_q == StGuard) ? grd_cnt_q + 1'b1 : '0;
        timeout_d  = timeout_q | timeout_hit;
        skew_sel_d = skew_sel_q;
        skew_val_d = skew_val_q;
        phase_d    = phase_q;
        dline_d    = dline_q;
        dvalid_d   = 1'b0;
        out_i_d    = out_i_q;
        out_q_d    = out_q_q;

        pat = (state_q == StTrain) || (state_q == StGuard) ||
              ((state_q == StData) && !bus.src_valid && IdlePattern);
        pay = (state_q == StData) && bus.src_valid;
        // A beat whose cycle ends in IDLE is dropped so IDLE never shows dvalid.
        beat = (pat || pay) && (state_d != StIdle);

        new_i  = pat ? pat_word(phase_q, 1'b0) : bus.src_i_data;
        new_q  = pat ? pat_word(phase_q, 1'b1) : bus.src_q_data;
        sk_in  = skew_sel_q ? new_q : new_i;
        sk_out = (skew_val_q == 4'd0) ? sk_in : dline_q[skew_val_q - 4'd1];

        if (beat) begin
            dvalid_d = 1'b1;
            out_i_d  = skew_sel_q ? new_i : sk_out;
            out_q_d  = skew_sel_q ? sk_out : new_q;
            if (pat) phase_d = ~phase_q;
            dline_d[0] = sk_in;
            for (int i = 1; i < int'(SKEW_MAX); i++) dline_d[i] = dline_q[i-1];
        end

        if ((state_q != StTrain) && (state_d == StTrain)) begin
            phase_d = 1'b0;
            for (int i = 0; i < int'(SKEW_MAX); i++) dline_d[i] = '0;
            if (state_q == StIdle) begin
                timeout_d  = 1'b0;
                skew_sel_d = skew_sel_qi;
                skew_val_d = (skew_val > 4'(SKEW_MAX)) ? 4'(SKEW_MAX) : skew_val;
            end
        end

        if (state_d == StIdle) begin
            out_i_d = '0;
            out_q_d = '0;
        end

        training_d = (state_d == StTrain) || (state_d == StGuard);
        state_o_d  = state_d;
    end

    assign bus.src_ready  = (state_q == StData) && en_train;
    assign bus.out_dvalid = dvalid_q;
    assign bus.out_i_data = out_i_q;
    assign bus.out_q_data = out_q_q;
    assign training       = training_q;
    assign train_timeout  = timeout_q;
    assign state_o        = state_o_q;
endmodule
